// File: rtl/wf_melody_sequencer_if.sv
// Bus bundle for the melody sequencer: CPU song load,
// transport commands, beat tick and tone outputs.
interface wf_melody_sequencer_if #(
   parameter int ADDR_W = 5
);
   logic              tick;
   logic              cmd_play;
   logic              cmd_stop;
   logic              cmd_pause;
   logic              loop_en;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [9:0]        wr_data;
   logic [15:0]       phase_inc;
   logic              note_active;
   logic              note_start;
   logic              busy;
   logic              paused;
   logic [ADDR_W-1:0] song_pos;
   logic              song_done;

   modport master (
      output tick, cmd_play, cmd_stop, cmd_pause,
      output loop_en, wr_en, wr_addr, wr_data,
      input  phase_inc, note_active, note_start,
      input  busy, paused, song_pos, song_done
   );

   modport slave (
      input  tick, cmd_play, cmd_stop, cmd_pause,
      input  loop_en, wr_en, wr_addr, wr_data,
      output phase_inc, note_active, note_start,
      output busy, paused, song_pos, song_done
   );
endinterface

// File: rtl/wf_melody_sequencer.sv
// Song RAM note sequencer feeding the tone phase accumulator.
// Steps entries on the beat tick with octave, rest and gap.
module wf_melody_sequencer #(
   parameter int ADDR_W    = 5,
   parameter int GAP_TICKS = 1
) (
   input  logic clk,
   input  logic rst,
   wf_melody_sequencer_if.slave bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_PLAY   = 3'd3;
   localparam logic [2:0] S_GAP    = 3'd4;
   localparam logic [2:0] S_PAUSED = 3'd5;

   localparam logic [3:0] GAP_LD =
      4'(GAP_TICKS > 0 ? GAP_TICKS - 1 : 0);

   logic [9:0]        mem [2**ADDR_W];
   logic [9:0]        mem_q;

   logic [2:0]        state_q, state_d;
   logic [2:0]        saved_q, saved_d;
   logic [ADDR_W-1:0] pos_q, pos_d;
   logic [3:0]        dur_q, dur_d;
   logic [3:0]        gap_q, gap_d;
   logic [15:0]       inc_q, inc_d;
   logic              act_q, act_d;
   logic              start_q, start_d;
   logic              done_q, done_d;

   logic [1:0]        oct;
   logic [3:0]        note;
   logic [3:0]        dur;
   logic              rest;
   logic [15:0]       base;
   logic [15:0]       scaled;
   logic              in_pause;

   assign oct  = mem_q[9:8];
   assign note = mem_q[7:4];
   assign dur  = mem_q[3:0];
   assign rest = (note >= 4'd12);

   function automatic logic [15:0] tone(input logic [3:0] n);
      case (n)
         4'd0:    return 16'd356;
         4'd1:    return 16'd378;
         4'd2:    return 16'd401;
         4'd3:    return 16'd424;
         4'd4:    return 16'd450;
         4'd5:    return 16'd476;
         4'd6:    return 16'd505;
         4'd7:    return 16'd534;
         4'd8:    return 16'd566;
         4'd9:    return 16'd599;
         4'd10:   return 16'd635;
         4'd11:   return 16'd674;
         default: return 16'd0;
      endcase
   endfunction

   // Song RAM: CPU write port, read port sampled in FETCH only
   always_ff @(posedge clk) begin
      if (bus.wr_en)
         mem[bus.wr_addr] <= bus.wr_data;
      if (state_q == S_FETCH)
         mem_q <= mem[pos_q];
   end

   // Octave shift of the base tone
   always_comb begin
      base   = tone(note);
      scaled = base;
      unique case (1'b1)
         (oct == 2'b10): scaled = base << 1;
         (oct == 2'b11): scaled = base >> 1;
         default:        scaled = base;
      endcase
   end

   // Sequencer next-state: stop wins, then the state step,
   // then a pause request parks the step's successor
   always_comb begin
      state_d = state_q;
      saved_d = saved_q;
      pos_d   = pos_q;
      dur_d   = dur_q;
      gap_d   = gap_q;
      inc_d   = inc_q;
      act_d   = act_q;
      start_d = 1'b0;
      done_d  = 1'b0;
      if (bus.cmd_stop) begin
         state_d = S_IDLE;
         pos_d   = '0;
         inc_d   = '0;
         act_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_play) begin
                  state_d = S_FETCH;
                  pos_d   = '0;
               end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
               if (oct == 2'b01) begin
                  if (bus.loop_en && pos_q != '0) begin
                     pos_d   = '0;
                     state_d = S_FETCH;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                     inc_d   = '0;
                     act_d   = 1'b0;
                  end
               end else begin
                  state_d = S_PLAY;
                  dur_d   = dur;
                  if (rest) begin
                     inc_d = '0;
                     act_d = 1'b0;
                  end else begin
                     inc_d   = scaled;
                     act_d   = 1'b1;
                     start_d = 1'b1;
                  end
               end
            end
            S_PLAY: begin
               if (bus.tick) begin
                  if (dur_q != 4'd0) begin
                     dur_d = dur_q - 4'd1;
                  end else if (GAP_TICKS > 0) begin
                     state_d = S_GAP;
                     gap_d   = GAP_LD;
                     inc_d   = '0;
                     act_d   = 1'b0;
                  end else begin
                     pos_d   = pos_q + 1'b1;
                     state_d = S_FETCH;
                  end
               end
            end
            S_GAP: begin
               if (bus.tick) begin
                  if (gap_q != 4'd0) begin
                     gap_d = gap_q - 4'd1;
                  end else begin
                     pos_d   = pos_q + 1'b1;
                     state_d = S_FETCH;
                  end
               end
            end
            S_PAUSED: begin
               if (bus.cmd_play || bus.cmd_pause)
                  state_d = saved_q;
            end
            default: state_d = S_IDLE;
         endcase
         if (bus.cmd_pause && !bus.cmd_play &&
             state_q inside {S_FETCH, S_DECODE,
                             S_PLAY, S_GAP} &&
             state_d != S_IDLE) begin
            saved_d = state_d;
            state_d = S_PAUSED;
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         saved_q <= S_IDLE;
         pos_q   <= '0;
         dur_q   <= '0;
         gap_q   <= '0;
         inc_q   <= '0;
         act_q   <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
         pos_q   <= pos_d;
         dur_q   <= dur_d;
         gap_q   <= gap_d;
         inc_q   <= inc_d;
         act_q   <= act_d;
         start_q <= start_d;
         done_q  <= done_d;
      end
   end

   assign in_pause        = (state_q == S_PAUSED);
   assign bus.phase_inc   = in_pause ? 16'd0 : inc_q;
   assign bus.note_active = act_q & ~in_pause;
   assign bus.note_start  = start_q & ~in_pause;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.paused      = in_pause;
   assign bus.song_pos    = pos_q;
   assign bus.song_done   = done_q;

endmodule

// File: tb/tb_wf_melody_sequencer.sv
// Directed bench for the melody sequencer: one instance with a
// one-tick gap, one with no gap for the address wrap case.
module tb_wf_melody_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   wf_melody_sequencer_if #(.ADDR_W(5)) b1 ();
   wf_melody_sequencer_if #(.ADDR_W(5)) b0 ();

   wf_melody_sequencer #(.ADDR_W(5), .GAP_TICKS(1)) dut1 (
      .clk(clk), .rst(rst), .bus(b1)
   );

   wf_melody_sequencer #(.ADDR_W(5), .GAP_TICKS(0)) dut0 (
      .clk(clk), .rst(rst), .bus(b0)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] ent(input logic [1:0] o,
                                      input logic [3:0] n,
                                      input logic [3:0] d);
      return {o, n, d};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr1(input logic [4:0] a, input logic [9:0] d);
      b1.wr_en = 1'b1; b1.wr_addr = a; b1.wr_data = d;
      cyc(1);
      b1.wr_en = 1'b0;
   endtask

   task automatic tk1();
      b1.tick = 1'b1; cyc(1); b1.tick = 1'b0;
   endtask

   task automatic play1();
      b1.cmd_play = 1'b1; cyc(1); b1.cmd_play = 1'b0;
   endtask

   // dur0 entry -> gap -> fetch -> decode: lands on next entry
   task automatic nxt1();
      tk1(); tk1(); cyc(2);
   endtask

   task automatic tk0();
      b0.tick = 1'b1; cyc(1); b0.tick = 1'b0;
   endtask

   initial begin
      b1.tick = 0; b1.cmd_play = 0; b1.cmd_stop = 0;
      b1.cmd_pause = 0; b1.loop_en = 0; b1.wr_en = 0;
      b1.wr_addr = '0; b1.wr_data = '0;
      b0.tick = 0; b0.cmd_play = 0; b0.cmd_stop = 0;
      b0.cmd_pause = 0; b0.loop_en = 0; b0.wr_en = 0;
      b0.wr_addr = '0; b0.wr_data = '0;
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(1);

      chk("rst_inc",  32'(b1.phase_inc), 32'd0);
      chk("rst_busy", 32'(b1.busy), 32'd0);
      chk("rst_pos",  32'(b1.song_pos), 32'd0);
      chk("rst_act",  32'(b1.note_active), 32'd0);

      // single note then END, gap of one tick
      wr1(5'd0, ent(2'b00, 4'd9, 4'd3));
      wr1(5'd1, ent(2'b01, 4'd0, 4'd0));
      play1();
      chk("t1_busy", 32'(b1.busy), 32'd1);
      chk("t1_lat0", 32'(b1.phase_inc), 32'd0);
      cyc(1);
      chk("t1_lat1", 32'(b1.phase_inc), 32'd0);
      cyc(1);
      chk("t1_inc",   32'(b1.phase_inc), 32'd599);
      chk("t1_start", 32'(b1.note_start), 32'd1);
      chk("t1_act",   32'(b1.note_active), 32'd1);
      cyc(1);
      chk("t1_start1", 32'(b1.note_start), 32'd0);
      tk1(); tk1(); tk1();
      chk("t1_tick3", 32'(b1.phase_inc), 32'd599);
      tk1();
      chk("t1_gap",  32'(b1.phase_inc), 32'd0);
      chk("t1_gapa", 32'(b1.note_active), 32'd0);
      tk1();
      chk("t1_pos1", 32'(b1.song_pos), 32'd1);
      cyc(2);
      chk("t1_done",  32'(b1.song_done), 32'd1);
      chk("t1_idle",  32'(b1.busy), 32'd0);
      cyc(1);
      chk("t1_done1", 32'(b1.song_done), 32'd0);

      // octave up, octave down, rest
      wr1(5'd0, ent(2'b10, 4'd0, 4'd0));
      wr1(5'd1, ent(2'b11, 4'd0, 4'd0));
      wr1(5'd2, ent(2'b00, 4'd12, 4'd0));
      wr1(5'd3, ent(2'b01, 4'd0, 4'd0));
      play1(); cyc(2);
      chk("t2_up", 32'(b1.phase_inc), 32'd712);
      nxt1();
      chk("t2_dn",    32'(b1.phase_inc), 32'd178);
      chk("t2_dn_st", 32'(b1.note_start), 32'd1);
      nxt1();
      chk("t2_rest",  32'(b1.phase_inc), 32'd0);
      chk("t2_rst_a", 32'(b1.note_active), 32'd0);
      chk("t2_rst_s", 32'(b1.note_start), 32'd0);
      chk("t2_rst_p", 32'(b1.song_pos), 32'd2);
      chk("t2_rst_b", 32'(b1.busy), 32'd1);
      nxt1();
      chk("t2_done", 32'(b1.song_done), 32'd1);
      chk("t2_idle", 32'(b1.busy), 32'd0);

      // loop over two entries, then stop+play together
      wr1(5'd0, ent(2'b00, 4'd1, 4'd0));
      wr1(5'd1, ent(2'b00, 4'd2, 4'd0));
      wr1(5'd2, ent(2'b01, 4'd0, 4'd0));
      b1.loop_en = 1'b1;
      play1(); cyc(2);
      chk("t3_p0", 32'(b1.song_pos), 32'd0);
      nxt1();
      chk("t3_p1", 32'(b1.song_pos), 32'd1);
      tk1(); tk1(); cyc(4);
      chk("t3_wrap",  32'(b1.song_pos), 32'd0);
      chk("t3_wrapi", 32'(b1.phase_inc), 32'd378);
      chk("t3_nodn",  32'(b1.song_done), 32'd0);
      nxt1();
      chk("t3_p1b", 32'(b1.song_pos), 32'd1);
      chk("t3_i1b", 32'(b1.phase_inc), 32'd401);
      b1.cmd_stop = 1'b1; b1.cmd_play = 1'b1;
      cyc(1);
      b1.cmd_stop = 1'b0; b1.cmd_play = 1'b0;
      chk("t5_busy", 32'(b1.busy), 32'd0);
      chk("t5_inc",  32'(b1.phase_inc), 32'd0);
      chk("t5_pos",  32'(b1.song_pos), 32'd0);
      chk("t5_done", 32'(b1.song_done), 32'd0);
      cyc(1);
      chk("t5_stay", 32'(b1.busy), 32'd0);

      // END at entry 0 never loops
      wr1(5'd0, ent(2'b01, 4'd0, 4'd0));
      play1(); cyc(2);
      chk("t3_e0done", 32'(b1.song_done), 32'd1);
      chk("t3_e0idle", 32'(b1.busy), 32'd0);
      b1.loop_en = 1'b0;

      // pause on tick 2 of a dur=3 note
      wr1(5'd0, ent(2'b00, 4'd9, 4'd3));
      wr1(5'd1, ent(2'b01, 4'd0, 4'd0));
      play1(); cyc(2);
      tk1();
      b1.tick = 1'b1; b1.cmd_pause = 1'b1;
      cyc(1);
      b1.tick = 1'b0; b1.cmd_pause = 1'b0;
      chk("t4_paused", 32'(b1.paused), 32'd1);
      chk("t4_pinc",   32'(b1.phase_inc), 32'd0);
      chk("t4_pact",   32'(b1.note_active), 32'd0);
      for (int i = 0; i < 10; i++) tk1();
      chk("t4_pinc10", 32'(b1.phase_inc), 32'd0);
      chk("t4_still",  32'(b1.paused), 32'd1);
      b1.cmd_pause = 1'b1; cyc(1); b1.cmd_pause = 1'b0;
      chk("t4_res_p", 32'(b1.paused), 32'd0);
      chk("t4_res_i", 32'(b1.phase_inc), 32'd599);
      chk("t4_res_a", 32'(b1.note_active), 32'd1);
      chk("t4_res_s", 32'(b1.note_start), 32'd0);
      tk1();
      chk("t4_tk1", 32'(b1.phase_inc), 32'd599);
      tk1();
      chk("t4_tk2", 32'(b1.phase_inc), 32'd0);
      b1.cmd_stop = 1'b1; cyc(1); b1.cmd_stop = 1'b0;

      // no-gap instance: 32 dur0 entries, wrap and RAW
      for (int i = 0; i < 32; i++) begin
         b0.wr_en = 1'b1;
         b0.wr_addr = 5'(i);
         b0.wr_data = ent(2'b00, 4'(i % 12), 4'd0);
         cyc(1);
      end
      b0.wr_en = 1'b0;
      b0.cmd_play = 1'b1; cyc(1); b0.cmd_play = 1'b0;
      cyc(2);
      chk("t6_e0", 32'(b0.phase_inc), 32'd356);
      for (int i = 1; i < 32; i++) begin
         tk0(); cyc(2);
      end
      chk("t6_p31", 32'(b0.song_pos), 32'd31);
      chk("t6_i31", 32'(b0.phase_inc), 32'd534);
      tk0();
      chk("t6_wrap", 32'(b0.song_pos), 32'd0);
      chk("t6_hold", 32'(b0.phase_inc), 32'd534);
      b0.wr_en = 1'b1; b0.wr_addr = 5'd0;
      b0.wr_data = ent(2'b00, 4'd5, 4'd0);
      cyc(1);
      b0.wr_en = 1'b0;
      cyc(1);
      chk("t6_old", 32'(b0.phase_inc), 32'd356);
      b0.cmd_stop = 1'b1; cyc(1); b0.cmd_stop = 1'b0;
      b0.cmd_play = 1'b1; cyc(1); b0.cmd_play = 1'b0;
      cyc(2);
      chk("t6_new", 32'(b0.phase_inc), 32'd476);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
